// File: rtl/tac_pulse_encoder.sv
// tac_pulse_encoder: turns a signed 8-bit activation into a train of single-cycle
// pulses on tac_in. The number of pulses equals the magnitude. The sign is
// presented on sign_x. Optional inter-pulse gap is enabled with TAC_ENC_GAP_EN.
// An abort ends the train early, and a done strobe marks the end of each
// transaction.
module tac_pulse_encoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] x_mag,
  input  logic       x_sign,
  input  logic       abort,
`ifdef TAC_ENC_GAP_EN
  input  logic [3:0] gap,
`endif
  output logic       tac_in,
  output logic       sign_x,
  output logic [7:0] pulse_cnt,
  output logic       done,
  output logic       aborted,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
`ifdef TAC_ENC_GAP_EN
    S_GAP   = 2'd3,
`endif
    S_DONE  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] cnt_q, cnt_d;
  logic       sign_q, sign_d;
  logic       aborted_q, aborted_d;
  logic       tac_in_q, tac_in_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
`ifdef TAC_ENC_GAP_EN
  logic [3:0] gap_q, gap_d;
  logic [3:0] gcnt_q, gcnt_d;
`endif

  // Next-state and datapath; outputs are decoded from the next state so they
  // come straight out of flops.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    aborted_d = aborted_q;
`ifdef TAC_ENC_GAP_EN
    gap_d     = gap_q;
    gcnt_d    = gcnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          rem_d     = x_mag;
          sign_d    = x_sign;
          cnt_d     = 8'd0;
          aborted_d = 1'b0;
`ifdef TAC_ENC_GAP_EN
          gap_d     = gap;
`endif
          state_d   = (x_mag == 8'd0) ? S_DONE : S_PULSE;
        end
      end
      S_PULSE: begin
        // The pulse on the wire this cycle always completes and is counted.
        rem_d = rem_q - 8'd1;
        cnt_d = cnt_q + 8'd1;
        if (rem_q == 8'd1) begin
          state_d = S_DONE;
        end else if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else begin
`ifdef TAC_ENC_GAP_EN
          if (gap_q != 4'd0) begin
            state_d = S_GAP;
            gcnt_d  = gap_q;
          end
`endif
        end
      end
`ifdef TAC_ENC_GAP_EN
      S_GAP: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else if (gcnt_q == 4'd1) begin
          state_d = S_PULSE;
        end else begin
          gcnt_d = gcnt_q - 4'd1;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    tac_in_d = (state_d == S_PULSE);
    done_d   = (state_d == S_DONE);
    busy_d   = (state_d != S_IDLE);
  end

  // State and output registers; reset kills any train in flight with no done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rem_q     <= 8'd0;
      cnt_q     <= 8'd0;
      sign_q    <= 1'b0;
      aborted_q <= 1'b0;
      tac_in_q  <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef TAC_ENC_GAP_EN
      gap_q     <= 4'd0;
      gcnt_q    <= 4'd0;
`endif
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      aborted_q <= aborted_d;
      tac_in_q  <= tac_in_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
`ifdef TAC_ENC_GAP_EN
      gap_q     <= gap_d;
      gcnt_q    <= gcnt_d;
`endif
    end
  end

  assign in_ready  = ~busy_q;
  assign tac_in    = tac_in_q;
  assign sign_x    = sign_q;
  assign pulse_cnt = cnt_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_tac_pulse_encoder.sv
// Directed bench for tac_pulse_encoder; build with TAC_ENC_GAP_EN to add the gap test.
module tb_tac_pulse_encoder;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] x_mag = 8'd0;
  logic       x_sign = 1'b0;
  logic       abort = 1'b0;
`ifdef TAC_ENC_GAP_EN
  logic [3:0] gap = 4'd0;
`endif
  logic       tac_in, sign_x, done, aborted, busy;
  logic [7:0] pulse_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // observations from the last watched transaction (k=1 is the cycle after accept)
  int npulses, first_k, last_k, done_k, done_cnt, sign_bad;

  tac_pulse_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x_mag(x_mag), .x_sign(x_sign), .abort(abort),
`ifdef TAC_ENC_GAP_EN
    .gap(gap),
`endif
    .tac_in(tac_in), .sign_x(sign_x), .pulse_cnt(pulse_cnt),
    .done(done), .aborted(aborted), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step through a transaction already offered on in_valid, recording pulses.
  // abort_after: raise abort while the Nth pulse is on the wire (0 = never).
  // valid_at: offer in_valid again during cycle k (0 = never).
  task automatic watch(input int abort_after, input int valid_at, input int limit, input logic exp_sign);
    int k;
    k = 0; npulses = 0; first_k = 0; last_k = 0; done_k = 0; done_cnt = 0; sign_bad = 0;
    while (k < limit && done_k == 0) begin
      step();
      k++;
      abort = 1'b0;
      in_valid = (k == valid_at);
      if (tac_in) begin
        npulses++;
        last_k = k;
        if (first_k == 0) first_k = k;
        if (npulses == abort_after) abort = 1'b1;
      end
      if (sign_x !== exp_sign) sign_bad = 1;
      if (done) begin
        done_k = k;
        done_cnt++;
      end
    end
    abort = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (done_k == 0) begin
      n_fail++;
      $display("FAIL watch_timeout: done not seen within %0d cycles", limit);
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (tac_in !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || aborted !== 1'b0 || sign_x !== 1'b0) begin
      n_fail++; $display("FAIL reset_outs: tac_in=%b done=%b busy=%b aborted=%b sign_x=%b, want all 0", tac_in, done, busy, aborted, sign_x);
    end
    n_checks++; if (pulse_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", pulse_cnt); end
    step(); step();
    rst = 1'b1;
    step();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    x_mag = 8'd5; x_sign = 1'b1; in_valid = 1'b1;
    watch(0, 0, 50, 1'b1);
    n_checks++; if (npulses != 5 || first_k != 1 || last_k != 5) begin
      n_fail++; $display("FAIL basic_pulses: n=%0d first=%0d last=%0d want 5/1/5", npulses, first_k, last_k);
    end
    n_checks++; if (done_k != 6) begin n_fail++; $display("FAIL basic_done: at %0d want 6", done_k); end
    n_checks++; if (pulse_cnt !== 8'd5 || aborted !== 1'b0) begin
      n_fail++; $display("FAIL basic_cnt: cnt=%0d aborted=%b want 5/0", pulse_cnt, aborted);
    end
    n_checks++; if (sign_bad != 0) begin n_fail++; $display("FAIL basic_sign: sign_x not held at 1"); end
    step();
    n_checks++; if (in_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL basic_ready: in_ready=%b done=%b want 1/0", in_ready, done);
    end
    step(); step();
    n_checks++; if (sign_x !== 1'b1) begin n_fail++; $display("FAIL sign_hold_idle: got %b want 1", sign_x); end
  endtask

  task automatic test_zero();
    x_mag = 8'd0; x_sign = 1'b0; in_valid = 1'b1;
    watch(0, 0, 10, 1'b0);
    n_checks++; if (npulses != 0 || done_k != 1 || pulse_cnt !== 8'd0) begin
      n_fail++; $display("FAIL zero: pulses=%0d done_at=%0d cnt=%0d want 0/1/0", npulses, done_k, pulse_cnt);
    end
    step();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_abort();
    // abort raised while the 10th pulse is on the wire: that pulse completes, nothing after
    x_mag = 8'd200; x_sign = 1'b1; in_valid = 1'b1;
    watch(10, 0, 400, 1'b1);
    n_checks++; if (npulses != 10 || done_k != 11) begin
      n_fail++; $display("FAIL abort_train: pulses=%0d done_at=%0d want 10/11", npulses, done_k);
    end
    n_checks++; if (pulse_cnt !== 8'd10 || aborted !== 1'b1) begin
      n_fail++; $display("FAIL abort_flags: cnt=%0d aborted=%b want 10/1", pulse_cnt, aborted);
    end
    // abort seen during DONE must not restart anything
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    n_checks++; if (tac_in !== 1'b0 || busy !== 1'b0 || pulse_cnt !== 8'd10) begin
      n_fail++; $display("FAIL abort_after: tac_in=%b busy=%b cnt=%0d want 0/0/10", tac_in, busy, pulse_cnt);
    end
  endtask

  task automatic test_abort_idle();
    abort = 1'b1;
    step();
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: busy=%b done=%b want 0/0", busy, done);
    end
    // abort with in_valid in IDLE is a normal accept, and clears aborted
    x_mag = 8'd2; x_sign = 1'b0; in_valid = 1'b1;
    watch(0, 0, 20, 1'b0);
    n_checks++; if (npulses != 2 || aborted !== 1'b0 || pulse_cnt !== 8'd2 || done_k != 3) begin
      n_fail++; $display("FAIL abort_accept: pulses=%0d aborted=%b cnt=%0d done_at=%0d want 2/0/2/3", npulses, aborted, pulse_cnt, done_k);
    end
    step();
  endtask

  task automatic test_max();
    x_mag = 8'd255; x_sign = 1'b1; in_valid = 1'b1;
    watch(0, 100, 400, 1'b1);
    n_checks++; if (npulses != 255 || last_k != 255 || done_k != 256) begin
      n_fail++; $display("FAIL max_train: pulses=%0d last=%0d done_at=%0d want 255/255/256", npulses, last_k, done_k);
    end
    n_checks++; if (pulse_cnt !== 8'd255) begin n_fail++; $display("FAIL max_cnt: got %0d want 255", pulse_cnt); end
    step(); step();
    n_checks++; if (busy !== 1'b0 || pulse_cnt !== 8'd255) begin
      n_fail++; $display("FAIL max_noqueue: busy=%b cnt=%0d want 0/255", busy, pulse_cnt);
    end
  endtask

`ifdef TAC_ENC_GAP_EN
  task automatic test_gap();
    x_mag = 8'd3; x_sign = 1'b0; gap = 4'd2; in_valid = 1'b1;
    watch(0, 0, 50, 1'b0);
    gap = 4'd0;
    n_checks++; if (npulses != 3 || first_k != 1 || last_k != 7 || done_k != 8) begin
      n_fail++; $display("FAIL gap_train: pulses=%0d first=%0d last=%0d done_at=%0d want 3/1/7/8", npulses, first_k, last_k, done_k);
    end
    step();
  endtask
`endif

  task automatic test_reset_mid();
    int dn;
    dn = 0;
    x_mag = 8'd20; x_sign = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    n_checks++; if (tac_in !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: tac_in=%b want 1", tac_in); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (tac_in !== 1'b0 || busy !== 1'b0 || pulse_cnt !== 8'd0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_async: tac_in=%b busy=%b cnt=%0d done=%b want 0/0/0/0", tac_in, busy, pulse_cnt, done);
    end
    for (int i = 0; i < 3; i++) begin step(); if (done) dn++; end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin step(); if (done) dn++; end
    n_checks++; if (dn != 0 || in_ready !== 1'b1 || pulse_cnt !== 8'd0) begin
      n_fail++; $display("FAIL rst_mid_after: done_seen=%0d in_ready=%b cnt=%0d want 0/1/0", dn, in_ready, pulse_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_abort();
    test_abort_idle();
    test_max();
`ifdef TAC_ENC_GAP_EN
    test_gap();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tac_pulse_encoder.md
TAC_PULSE_ENCODER -- requirements
Module: tac_pulse_encoder

Interface
REQ-001 The block SHALL have one clock domain and an asynchronous active-low reset, with ports named as follows.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  asynchronous reset, active-low: 0 = reset, 1 = run.
REQ-004 in_valid  in  1  a signed activation is offered on x_mag/x_sign.
REQ-005 in_ready  out  1  the encoder accepts an activation; asserted only in IDLE.
REQ-006 x_mag  in  8  unsigned activation magnitude, 0..255 pulses.
REQ-007 x_sign  in  1  activation sign (1 = negative); drives the TAC sign_x input.
REQ-008 abort  in  1  synchronous request to end the current transaction early.
REQ-009 tac_in  out  1  single-cycle pulse train, one pulse per unit of magnitude.
REQ-010 sign_x  out  1  registered copy of x_sign, captured at accept.
REQ-011 pulse_cnt  out  8  pulses emitted in the current or last transaction.
REQ-012 done  out  1  one-cycle strobe marking the end of a transaction.
REQ-013 aborted  out  1  set when the last transaction ended by abort.
REQ-014 busy  out  1  high in every state other than IDLE.
REQ-015 gap  in  4  idle cycles inserted between consecutive pulses; port exists only with TAC_ENC_GAP_EN.

Function
REQ-016 The FSM SHALL have four states: IDLE, PULSE, GAP, DONE.
REQ-017 Accept: in IDLE, in_valid=1 at an edge SHALL latch x_mag into a remaining counter and x_sign into sign_x, clear pulse_cnt, clear aborted, and leave IDLE.
REQ-018 After accept, x_mag=0 SHALL go directly to DONE with no pulse; x_mag>0 SHALL go to PULSE.
REQ-019 In PULSE, tac_in SHALL be 1 for exactly one cycle, the remaining counter SHALL decrement, and pulse_cnt SHALL increment.
REQ-020 After a pulse: if remaining=0, go to DONE; else if the effective gap>0, go to GAP; otherwise go to PULSE again, giving back-to-back pulses.
REQ-021 GAP SHALL last exactly gap cycles with tac_in=0, then return to PULSE; gap is sampled at accept and held for the whole transaction.
REQ-022 No gap SHALL be inserted after the last pulse.
REQ-023 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-024 Timing with accept at edge T and effective gap 0:
- pulses at cycles T+1..T+N;
- done at T+N+1;
- in_ready at T+N+2.
REQ-025 Timing with effective gap G and N>0: the last pulse SHALL occur at T+1+(N-1)(G+1).
REQ-026 tac_in, sign_x, done, busy and in_ready SHALL be registered or derived directly from state; none may combinationally depend on in_valid or abort.
REQ-027 sign_x SHALL hold its value from accept until the next accept, including through IDLE.
REQ-028 abort=1 in PULSE or GAP SHALL move to DONE at the next edge.
- No further pulses are emitted; a pulse already being driven in the current cycle completes.
- aborted is set to 1.
- pulse_cnt freezes.
REQ-029 abort SHALL be ignored in IDLE and in DONE; abort together with in_valid in IDLE SHALL perform a normal accept.
REQ-030 in_valid while busy SHALL be ignored; no input is queued.
REQ-031 x_mag=255 SHALL produce exactly 255 pulses, and pulse_cnt SHALL reach 255 without wrapping.

Reset
REQ-032 rst=0 SHALL immediately force the following values, regardless of clk:
- state = IDLE;
- tac_in, sign_x, done, aborted, busy = 0;
- pulse_cnt = 0, remaining = 0;
- in_ready = 1 after rst returns to 1.
REQ-033 Reset during PULSE or GAP SHALL end the pulse train with no done strobe.

Configuration
REQ-034 With TAC_ENC_GAP_EN defined, the gap port and the GAP state SHALL exist and behave per REQ-021.
REQ-035 Without TAC_ENC_GAP_EN, the gap port and the GAP state SHALL be absent, and the effective gap SHALL be the constant 0 (back-to-back pulses only).

Verification
REQ-036 Accept x_mag=5, x_sign=1, gap=0 -> 5 consecutive tac_in pulses; sign_x=1 throughout; pulse_cnt=5; done one cycle later; aborted=0.
REQ-037 Accept x_mag=0 -> no tac_in pulse; done at T+1; in_ready at T+2; pulse_cnt=0.
REQ-038 TAC_ENC_GAP_EN defined, accept x_mag=3, gap=2 -> pulses at T+1, T+4, T+7; done at T+8.
REQ-039 Accept x_mag=200, assert abort after the 10th pulse -> pulse_cnt=10; aborted=1; done one cycle later; no further pulses.
REQ-040 Accept x_mag=255 -> 255 pulses; pulse_cnt=255; in_valid pulsed mid-train is ignored.
REQ-041 rst=0 in mid-train -> tac_in=0 immediately; done never asserted; after release, in_ready=1 and pulse_cnt=0.
